// File: rtl/flag_branch_unit_if.sv
// rtl/flag_branch_unit_if.sv - ALU flag commit and branch request bundle for flag_branch_unit
//
// Signals:
//   alu_valid  1  ALU result this cycle is architectural (commit flags)
//   alu_op     3  opcode of the committing instruction
//   alu_flags  3  ALU flags {Z,V,N}
//   br_valid   1  branch request, held with br_ccc stable until accepted
//   br_ccc     3  branch condition code
//   br_ready   1  branch accepted when br_valid & br_ready
//   br_done    1  one-cycle pulse, resolution result valid
//   br_taken   1  condition outcome, valid while br_done=1
//   flags_q    3  current flag register {Z,V,N}
// Modports: master = EX/fetch side driving requests, slave = flag_branch_unit.

interface flag_branch_unit_if;
    logic       alu_valid;
    logic [2:0] alu_op;
    logic [2:0] alu_flags;
    logic       br_valid;
    logic [2:0] br_ccc;
    logic       br_ready;
    logic       br_done;
    logic       br_taken;
    logic [2:0] flags_q;

    modport master (
        output alu_valid, alu_op, alu_flags, br_valid, br_ccc,
        input  br_ready, br_done, br_taken, flags_q
    );

    modport slave (
        input  alu_valid, alu_op, alu_flags, br_valid, br_ccc,
        output br_ready, br_done, br_taken, flags_q
    );
endinterface

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - architectural flag register and branch condition resolver
//
// Holds the {Z,V,N} flag register, updates it under a per-opcode write mask when
// the ALU commits, and resolves 3-bit branch condition codes against it.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    flag_branch_unit_if.slave (alu_valid/alu_op/alu_flags in,
//          br_valid/br_ccc in, br_ready/br_done/br_taken/flags_q out)
//
// Build option: define FLAG_FWD_EN to forward the in-flight flag write into the
// branch evaluation instead of stalling one cycle in WAIT.

module flag_branch_unit (
    input  logic                  clk,
    input  logic                  rst_n,
    flag_branch_unit_if.slave     bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [2:0] flags_r;
    logic [2:0] wr_mask;
    logic [2:0] flags_merged;
    logic [2:0] eval_flags;
    logic       wr_hit;
    logic       accept;
    logic       ready;
    logic       done_r;
    logic       taken_r;

    // Which flag bits each opcode is allowed to write.
    function automatic logic [2:0] op_mask(input logic [2:0] op);
        case (op)
            3'b000, 3'b001:                 op_mask = 3'b111;   // ADD, SUB
            3'b010, 3'b100, 3'b101, 3'b110: op_mask = 3'b100;   // XOR, SLL, SRA, ROR
            default:                        op_mask = 3'b000;   // RED, PADSUB
        endcase
    endfunction

    // Condition table; f = {Z,V,N}.
    function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (ccc)
            3'b000:  cond_eval = ~z;                 // NE
            3'b001:  cond_eval = z;                  // EQ
            3'b010:  cond_eval = ~z & ~n;            // GT
            3'b011:  cond_eval = n;                  // LT
            3'b100:  cond_eval = z | (~z & ~n);      // GE
            3'b101:  cond_eval = n | z;              // LE
            3'b110:  cond_eval = v;                  // OV
            default: cond_eval = 1'b1;               // always
        endcase
    endfunction

    assign wr_mask      = op_mask(bus.alu_op);
    assign wr_hit       = bus.alu_valid & (wr_mask != 3'b000);
    // Next-state flag value: masked bits from the ALU, the rest held.
    assign flags_merged = (flags_r & ~wr_mask) | (bus.alu_flags & wr_mask);

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 3'b000;
        end else if (wr_hit) begin
            flags_r <= flags_merged;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = S_IDLE;
`ifdef FLAG_FWD_EN
        state_d = S_IDLE;
`else
        case (state_q)
            // A branch colliding with a flag write waits for the write to land.
            S_IDLE:  state_d = (bus.br_valid & wr_hit) ? S_WAIT : S_IDLE;
            // Either the held branch is accepted or the requester withdrew.
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`endif
    end

    // FSM: outputs (handshake and the flags used for evaluation)
    always_comb begin
        ready      = 1'b1;
        accept     = 1'b0;
        eval_flags = flags_r;
        case (state_q)
            S_IDLE: begin
`ifdef FLAG_FWD_EN
                ready = 1'b1;
                if (wr_hit) begin
                    eval_flags = flags_merged;
                end
`else
                ready = ~(bus.br_valid & wr_hit);
`endif
                accept = bus.br_valid & ready;
            end
            S_WAIT: begin
                // flags_r already holds the older write; a write arriving now is
                // younger and must not affect this branch.
                ready  = 1'b1;
                accept = bus.br_valid;
            end
            default: begin
                ready  = 1'b1;
                accept = 1'b0;
            end
        endcase
    end

    // Registered resolution result; taken is forced low whenever done is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r  <= 1'b0;
            taken_r <= 1'b0;
        end else begin
            done_r  <= accept;
            taken_r <= accept & cond_eval(bus.br_ccc, eval_flags);
        end
    end

    assign bus.br_ready = ready;
    assign bus.br_done  = done_r;
    assign bus.br_taken = taken_r;
    assign bus.flags_q  = flags_r;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed table-driven bench for flag_branch_unit

module tb_flag_branch_unit;

    logic clk;
    logic rst_n;

    flag_branch_unit_if bus();

    flag_branch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       valid;
        logic [2:0] op;
        logic [2:0] init_flags;
        logic [2:0] alu_flags;
        logic [2:0] exp_flags;
    } mask_vec_t;

    typedef struct {
        logic [2:0] ccc;
        logic [7:0] taken_by_flags;   // bit f = expected taken when flags_q == f
    } ccc_vec_t;

    mask_vec_t mask_tab[9];
    ccc_vec_t  ccc_tab[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_op    = 3'b000;
        bus.alu_flags = 3'b000;
        bus.br_valid  = 1'b0;
        bus.br_ccc    = 3'b000;
    endtask

    // Full write of all three flags through an ADD commit.
    task automatic load_flags(input logic [2:0] f);
        bus.alu_valid = 1'b1;
        bus.alu_op    = 3'b000;
        bus.alu_flags = f;
        step();
        bus.alu_valid = 1'b0;
    endtask

    initial begin
        mask_tab[0] = '{1'b1, 3'b010, 3'b000, 3'b111, 3'b100};
        mask_tab[1] = '{1'b1, 3'b100, 3'b011, 3'b000, 3'b011};
        mask_tab[2] = '{1'b1, 3'b101, 3'b000, 3'b011, 3'b000};
        mask_tab[3] = '{1'b1, 3'b110, 3'b010, 3'b101, 3'b110};
        mask_tab[4] = '{1'b1, 3'b001, 3'b000, 3'b101, 3'b101};
        mask_tab[5] = '{1'b1, 3'b011, 3'b101, 3'b010, 3'b101};
        mask_tab[6] = '{1'b1, 3'b111, 3'b110, 3'b001, 3'b110};
        mask_tab[7] = '{1'b1, 3'b000, 3'b111, 3'b010, 3'b010};
        mask_tab[8] = '{1'b0, 3'b000, 3'b101, 3'b010, 3'b101};

        ccc_tab[0] = '{3'd0, 8'h0F};   // NE
        ccc_tab[1] = '{3'd1, 8'hF0};   // EQ
        ccc_tab[2] = '{3'd2, 8'h05};   // GT
        ccc_tab[3] = '{3'd3, 8'hAA};   // LT
        ccc_tab[4] = '{3'd4, 8'hF5};   // GE
        ccc_tab[5] = '{3'd5, 8'hFA};   // LE
        ccc_tab[6] = '{3'd6, 8'hCC};   // OV
        ccc_tab[7] = '{3'd7, 8'hFF};   // always

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        check("reset_flags", {5'b0, bus.flags_q}, 8'h00);
        check("reset_done", {7'b0, bus.br_done}, 8'h00);
        check("reset_taken", {7'b0, bus.br_taken}, 8'h00);
        rst_n = 1'b1;
        step();
        check("reset_ready", {7'b0, bus.br_ready}, 8'h01);

        // ADD overflow 0x7FFF+1 -> {Z,V,N}=011, then OV branch
        load_flags(3'b011);
        check("add_flags", {5'b0, bus.flags_q}, 8'h03);
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b110;
        #1;
        check("ov_ready", {7'b0, bus.br_ready}, 8'h01);
        step();
        bus.br_valid = 1'b0;
        check("ov_done", {7'b0, bus.br_done}, 8'h01);
        check("ov_taken", {7'b0, bus.br_taken}, 8'h01);
        step();
        check("ov_done_pulse", {7'b0, bus.br_done}, 8'h00);
        check("ov_taken_clr", {7'b0, bus.br_taken}, 8'h00);

        // XOR writes Z only, RED writes nothing
        bus.alu_valid = 1'b1;
        bus.alu_op    = 3'b010;
        bus.alu_flags = 3'b100;
        step();
        check("xor_flags", {5'b0, bus.flags_q}, 8'h07);
        bus.alu_op    = 3'b011;
        bus.alu_flags = 3'b000;
        step();
        bus.alu_valid = 1'b0;
        check("red_flags", {5'b0, bus.flags_q}, 8'h07);
        // back-to-back EQ then NE
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b001;
        step();
        check("eq_done", {7'b0, bus.br_done}, 8'h01);
        check("eq_taken", {7'b0, bus.br_taken}, 8'h01);
        bus.br_ccc = 3'b000;
        step();
        bus.br_valid = 1'b0;
        check("ne_done_b2b", {7'b0, bus.br_done}, 8'h01);
        check("ne_taken", {7'b0, bus.br_taken}, 8'h00);
        step();
        check("b2b_done_end", {7'b0, bus.br_done}, 8'h00);

        // write-mask table
        for (int i = 0; i < 9; i++) begin
            load_flags(mask_tab[i].init_flags);
            bus.alu_valid = mask_tab[i].valid;
            bus.alu_op    = mask_tab[i].op;
            bus.alu_flags = mask_tab[i].alu_flags;
            step();
            bus.alu_valid = 1'b0;
            check($sformatf("mask_op%0d_v%0d", mask_tab[i].op, mask_tab[i].valid),
                  {5'b0, bus.flags_q}, {5'b0, mask_tab[i].exp_flags});
        end

        // all condition codes against all flag values
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                load_flags(3'(f));
                bus.br_valid = 1'b1;
                bus.br_ccc   = ccc_tab[c].ccc;
                step();
                bus.br_valid = 1'b0;
                check($sformatf("ccc%0d_f%0d_done", c, f), {7'b0, bus.br_done}, 8'h01);
                check($sformatf("ccc%0d_f%0d_taken", c, f), {7'b0, bus.br_taken},
                      {7'b0, ccc_tab[c].taken_by_flags[f]});
            end
        end

        // hazard: SUB writing Z together with an EQ branch
        load_flags(3'b000);
        bus.alu_valid = 1'b1;
        bus.alu_op    = 3'b001;
        bus.alu_flags = 3'b100;
        bus.br_valid  = 1'b1;
        bus.br_ccc    = 3'b001;
        #1;
`ifdef FLAG_FWD_EN
        check("haz_ready_fwd", {7'b0, bus.br_ready}, 8'h01);
        step();
        bus.alu_valid = 1'b0;
        bus.br_valid  = 1'b0;
        check("haz_done_fwd", {7'b0, bus.br_done}, 8'h01);
        check("haz_taken_fwd", {7'b0, bus.br_taken}, 8'h01);
        step();
`else
        check("haz_ready_stall", {7'b0, bus.br_ready}, 8'h00);
        step();
        bus.alu_valid = 1'b0;
        check("haz_wait_done", {7'b0, bus.br_done}, 8'h00);
        check("haz_wait_flags", {5'b0, bus.flags_q}, 8'h04);
        check("haz_wait_ready", {7'b0, bus.br_ready}, 8'h01);
        step();
        bus.br_valid = 1'b0;
        check("haz_done", {7'b0, bus.br_done}, 8'h01);
        check("haz_taken", {7'b0, bus.br_taken}, 8'h01);
        step();
        check("haz_done_pulse", {7'b0, bus.br_done}, 8'h00);

        // younger write during WAIT updates flags_q but not the held branch
        load_flags(3'b000);
        bus.alu_valid = 1'b1;
        bus.alu_op    = 3'b001;
        bus.alu_flags = 3'b100;
        bus.br_valid  = 1'b1;
        bus.br_ccc    = 3'b001;
        step();
        bus.alu_flags = 3'b000;
        #1;
        check("young_ready", {7'b0, bus.br_ready}, 8'h01);
        step();
        bus.alu_valid = 1'b0;
        bus.br_valid  = 1'b0;
        check("young_done", {7'b0, bus.br_done}, 8'h01);
        check("young_taken", {7'b0, bus.br_taken}, 8'h01);
        check("young_flags", {5'b0, bus.flags_q}, 8'h00);
        step();
        check("young_no_second", {7'b0, bus.br_done}, 8'h00);

        // requester withdraws in WAIT
        bus.alu_valid = 1'b1;
        bus.alu_op    = 3'b001;
        bus.alu_flags = 3'b100;
        bus.br_valid  = 1'b1;
        bus.br_ccc    = 3'b111;
        step();
        bus.alu_valid = 1'b0;
        bus.br_valid  = 1'b0;
        step();
        check("withdraw_done_a", {7'b0, bus.br_done}, 8'h00);
        step();
        check("withdraw_done_b", {7'b0, bus.br_done}, 8'h00);
        // back in IDLE: a fresh branch resolves with single-cycle latency
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b001;
        step();
        bus.br_valid = 1'b0;
        check("withdraw_idle_done", {7'b0, bus.br_done}, 8'h01);
        check("withdraw_idle_taken", {7'b0, bus.br_taken}, 8'h01);
        step();
`endif

        // reset asserted mid-WAIT (or mid-result when forwarding)
        load_flags(3'b000);
        bus.alu_valid = 1'b1;
        bus.alu_op    = 3'b001;
        bus.alu_flags = 3'b100;
        bus.br_valid  = 1'b1;
        bus.br_ccc    = 3'b001;
        step();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check("rst_wait_flags", {5'b0, bus.flags_q}, 8'h00);
        check("rst_wait_done", {7'b0, bus.br_done}, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        check("rst_release_done_a", {7'b0, bus.br_done}, 8'h00);
        step();
        check("rst_release_done_b", {7'b0, bus.br_done}, 8'h00);
        check("rst_release_ready", {7'b0, bus.br_ready}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
